// File: rtl/irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared constants for the interrupt controller: register-select codes for the
// select/write/read port and the FSM state encoding. STAT bits 15:14 expose
// the state encoding, so these values are visible to software.
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

  // Register width of the select/write/read port.
  localparam int REG_W = 16;

  // Register select codes (reg_sel).
  localparam logic [2:0] SEL_PEND = 3'd0;
  localparam logic [2:0] SEL_MASK = 3'd1;
  localparam logic [2:0] SEL_EDGE = 3'd2;
  localparam logic [2:0] SEL_STAT = 3'd3;
  localparam logic [2:0] SEL_EOI  = 3'd4;
  localparam logic [2:0] SEL_SWI  = 3'd5;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

endpackage

// File: rtl/irq_ctrl_sync.sv
// -----------------------------------------------------------------------------
// irq_sync
// Per-source synchroniser: two metastability flops (s1, s2) followed by a
// history flop (s3) used for rising-edge detection.
// Ports:
//   clk      core clock
//   rst      asynchronous active-low reset
//   i_async  raw asynchronous request line
//   o_level  synchronised level (s2)
//   o_rise   one-cycle rising-edge indication (s2 & ~s3)
// -----------------------------------------------------------------------------
module irq_sync
  import irq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Three-stage shift: two synchroniser stages plus one history stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
// Multi-source interrupt controller in front of the core's single irq_in.
// Synchronises N request lines, latches edge requests / tracks level requests
// in a pending register, masks and fixed-priority arbitrates them (lowest
// index wins), and runs an IDLE -> REQ -> SERVICE handshake with the core.
// A new request is held off until software writes EOI.
// Ports:
//   clk        core clock
//   rst        asynchronous active-low reset
//   irq_src    raw asynchronous request lines [N-1:0]
//   reg_sel    register select (PEND/MASK/EDGE/STAT/EOI/SWI)
//   reg_we     one-cycle register write strobe
//   reg_wdata  register write data
//   reg_rdata  register read data, combinational from reg_sel
//   irq_out    request to the core (high only in REQ)
//   irq_take   core accepted the interrupt
//   irq_id     id of the requested / in-service source
// -----------------------------------------------------------------------------
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N   = 8,
  parameter int IDW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     irq_src,
  input  logic [2:0]       reg_sel,
  input  logic             reg_we,
  input  logic [REG_W-1:0] reg_wdata,
  output logic [REG_W-1:0] reg_rdata,
  output logic             irq_out,
  input  logic             irq_take,
  output logic [IDW-1:0]   irq_id
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [N-1:0]   w_lvl;
  logic [N-1:0]   w_rise;
  logic [N-1:0]   w_wd;

  logic           w_wr_pend;
  logic           w_wr_mask;
  logic           w_wr_edge;
  logic           w_wr_eoi;
  logic           w_wr_swi;

  logic [N-1:0]   r_pend;
  logic [N-1:0]   r_mask;
  logic [N-1:0]   r_edge;
  logic [1:0]     r_state;
  logic [IDW-1:0] r_id;
  logic           r_irq_out;

  logic [N-1:0]   w_act;
  logic           w_any;
  logic [IDW-1:0] w_win;
  logic [N-1:0]   w_id_oh;
  logic           w_take;

  logic [1:0]     w_state_n;
  logic [IDW-1:0] w_id_n;

  logic [N-1:0]   w_edge_set;
  logic [N-1:0]   w_edge_clr;
  logic [N-1:0]   w_mode_chg;
  logic [N-1:0]   w_pend_n;

  // ---------------------------------------------------------------------------
  // Synchronisers, one per source
  // ---------------------------------------------------------------------------
  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_sync
      irq_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (irq_src[g]),
        .o_level (w_lvl[g]),
        .o_rise  (w_rise[g])
      );
    end
  endgenerate

  // Write data bits above the source count carry no meaning.
  generate
    if (N < REG_W) begin : g_unused
      logic w_unused_hi;
      assign w_unused_hi = ^reg_wdata[REG_W-1:N];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Register write decode
  // ---------------------------------------------------------------------------
  assign w_wd      = reg_wdata[N-1:0];
  assign w_wr_pend = reg_we & (reg_sel == SEL_PEND);
  assign w_wr_mask = reg_we & (reg_sel == SEL_MASK);
  assign w_wr_edge = reg_we & (reg_sel == SEL_EDGE);
  assign w_wr_eoi  = reg_we & (reg_sel == SEL_EOI);
  assign w_wr_swi  = reg_we & (reg_sel == SEL_SWI);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign w_act  = r_pend & r_mask;
  assign w_take = (r_state == ST_REQ) & irq_take;

  // Fixed-priority encoder: scanning downwards leaves the lowest index last.
  always_comb begin
    w_any = 1'b0;
    w_win = {IDW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_any = 1'b1;
        w_win = IDW'(i);
      end else begin
        w_any = w_any;
        w_win = w_win;
      end
    end
  end

  // One-hot of the frozen id, used to test and clear its pending bit.
  always_comb begin
    w_id_oh = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_id_oh[i] = (r_id == IDW'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  // Next-state and id selection; id only changes on the IDLE -> REQ edge.
  always_comb begin
    w_state_n = r_state;
    w_id_n    = r_id;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_n = ST_REQ;
          w_id_n    = w_win;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Take is checked first so it wins over a concurrent mask-off/clear.
        if (irq_take) begin
          w_state_n = ST_SERVICE;
        end else if ((w_act & w_id_oh) == {N{1'b0}}) begin
          w_state_n = ST_IDLE;
        end else begin
          w_state_n = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (w_wr_eoi) begin
          w_state_n = ST_IDLE;
        end else begin
          w_state_n = ST_SERVICE;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_id_n    = {IDW{1'b0}};
      end
    endcase
  end

  // State, id and the registered request output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_id      <= {IDW{1'b0}};
      r_irq_out <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_id      <= w_id_n;
      r_irq_out <= (w_state_n == ST_REQ);
    end
  end

  assign irq_out = r_irq_out;
  assign irq_id  = r_id;

  // ---------------------------------------------------------------------------
  // Pending register
  // ---------------------------------------------------------------------------
  // Edge bits: set (hardware edge or SWI) wins over clear (W1C or take).
  // Level bits: follow the synchronised line. A mode change clears the bit.
  always_comb begin
    w_edge_set = w_rise | (w_wr_swi ? w_wd : {N{1'b0}});
    w_edge_clr = (w_wr_pend ? w_wd : {N{1'b0}}) |
                 (w_take ? w_id_oh : {N{1'b0}});
    w_mode_chg = w_wr_edge ? (w_wd ^ r_edge) : {N{1'b0}};
    w_pend_n   = ((r_edge & ((r_pend & ~w_edge_clr) | w_edge_set)) |
                  (~r_edge & w_lvl)) & ~w_mode_chg;
  end

  // Pending state update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= {N{1'b0}};
    end else begin
      r_pend <= w_pend_n;
    end
  end

  // MASK and EDGE configuration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask <= {N{1'b0}};
      r_edge <= {N{1'b0}};
    end else begin
      if (w_wr_mask) begin
        r_mask <= w_wd;
      end else begin
        r_mask <= r_mask;
      end
      if (w_wr_edge) begin
        r_edge <= w_wd;
      end else begin
        r_edge <= r_edge;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  // Combinational read; unused bits and write-only selects read as zero.
  always_comb begin
    reg_rdata = {REG_W{1'b0}};
    case (reg_sel)
      SEL_PEND: reg_rdata[N-1:0] = r_pend;
      SEL_MASK: reg_rdata[N-1:0] = r_mask;
      SEL_EDGE: reg_rdata[N-1:0] = r_edge;
      SEL_STAT: begin
        reg_rdata[REG_W-1:REG_W-2] = r_state;
        reg_rdata[IDW-1:0]         = r_id;
      end
      default: reg_rdata = {REG_W{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
// Directed scenarios followed by randomized traffic, all checked against a
// cycle-level reference model built from the controller's rules: the
// synchroniser is a history of sampled source vectors, pending/mask/edge are
// plain bit vectors, and arbitration is a first-set-bit search.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

  localparam int N   = 8;
  localparam int IDW = 4;

  logic         clk;
  logic         rst;
  logic [7:0]   irq_src;
  logic [2:0]   reg_sel;
  logic         reg_we;
  logic [15:0]  reg_wdata;
  logic [15:0]  reg_rdata;
  logic         irq_out;
  logic         irq_take;
  logic [3:0]   irq_id;

  int n_checks;
  int n_errors;

  // Reference model state.
  logic [7:0] m_pend;
  logic [7:0] m_mask;
  logic [7:0] m_edge;
  logic [1:0] m_st;     // 0 idle, 1 req, 2 service
  logic [3:0] m_id;
  logic [7:0] m_q[$];   // sampled irq_src, newest first

  logic [7:0]  cur_src;
  logic [15:0] d;

  irq_ctrl #(.N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .reg_sel   (reg_sel),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq_out   (irq_out),
    .irq_take  (irq_take),
    .irq_id    (irq_id)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pend = 8'h00;
    m_mask = 8'h00;
    m_edge = 8'h00;
    m_st   = 2'd0;
    m_id   = 4'd0;
    m_q    = '{8'h00, 8'h00, 8'h00, 8'h00};
  endtask

  function automatic logic [15:0] m_read(input int s);
    case (s)
      0:       return {8'h00, m_pend};
      1:       return {8'h00, m_mask};
      2:       return {8'h00, m_edge};
      3:       return {m_st, 10'b0, m_id};
      default: return 16'h0000;
    endcase
  endfunction

  // One clock edge of the reference model, given the inputs at that edge.
  task automatic m_step(input logic [7:0] src, input logic [2:0] sel, input logic we,
                        input logic [15:0] wd, input logic tk);
    logic [7:0] act, rise, lvl, set_v, clr_v, nxt, chg;
    logic [1:0] st_n;
    int win;
    act   = m_pend & m_mask;
    win   = -1;
    for (int i = 0; i < 8; i++) begin
      if (act[i]) begin
        win = i;
        break;
      end
    end
    // Line sampled two edges ago is what the pending logic sees now.
    rise  = m_q[1] & ~m_q[2];
    lvl   = m_q[1];
    clr_v = (we && sel == 3'd0) ? wd[7:0] : 8'h00;
    set_v = rise | ((we && sel == 3'd5) ? wd[7:0] : 8'h00);
    st_n  = m_st;
    case (m_st)
      2'd0: if (win >= 0) begin st_n = 2'd1; m_id = 4'(win); end
      2'd1: begin
        if (tk) begin
          st_n = 2'd2;
          clr_v[m_id] = 1'b1;
        end else if (!act[m_id]) begin
          st_n = 2'd0;
        end
      end
      2'd2: if (we && sel == 3'd4) st_n = 2'd0;
      default: st_n = 2'd0;
    endcase
    nxt = (m_edge & ((m_pend & ~clr_v) | set_v)) | (~m_edge & lvl);
    if (we && sel == 3'd2) begin
      chg    = m_edge ^ wd[7:0];
      nxt    = nxt & ~chg;
      m_edge = wd[7:0];
    end
    if (we && sel == 3'd1) m_mask = wd[7:0];
    m_pend = nxt;
    m_st   = st_n;
    m_q.push_front(src);
    void'(m_q.pop_back());
  endtask

  // Compare outputs and every register against the model (at negedge).
  task automatic check_all();
    chk("irq_out", {15'b0, irq_out}, {15'b0, (m_st == 2'd1)});
    chk("irq_id", {12'b0, irq_id}, {12'b0, m_id});
    for (int s = 0; s < 8; s++) begin
      reg_sel = 3'(s);
      #1;
      chk($sformatf("rd%0d", s), reg_rdata, m_read(s));
    end
  endtask

  task automatic cyc(input logic [7:0] src, input logic [2:0] sel, input logic we,
                     input logic [15:0] wd, input logic tk);
    cur_src   = src;
    irq_src   = src;
    reg_sel   = sel;
    reg_we    = we;
    reg_wdata = wd;
    irq_take  = tk;
    @(posedge clk);
    m_step(src, sel, we, wd, tk);
    @(negedge clk);
    reg_we   = 1'b0;
    irq_take = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(cur_src, 3'd0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic rd(input logic [2:0] sel, output logic [15:0] v);
    reg_sel = sel;
    #1;
    v = reg_rdata;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    irq_src   = 8'h00;
    cur_src   = 8'h00;
    reg_sel   = 3'd0;
    reg_we    = 1'b0;
    reg_wdata = 16'h0000;
    irq_take  = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b1;

    // Masked edge source latches in PEND without requesting.
    cyc(8'h00, 3'd1, 1'b1, 16'h0000, 1'b0);
    cyc(8'h00, 3'd2, 1'b1, 16'h0001, 1'b0);
    repeat (3) cyc(8'h01, 3'd0, 1'b0, 16'h0000, 1'b0);
    repeat (3) cyc(8'h00, 3'd0, 1'b0, 16'h0000, 1'b0);
    rd(3'd0, d);
    chk("t1_pend", d, 16'h0001);
    chk("t1_irq", {15'b0, irq_out}, 16'h0000);
    cyc(8'h00, 3'd0, 1'b1, 16'h00FF, 1'b0);

    // Two simultaneous edges: priority, latency, take, EOI re-request.
    cyc(8'h00, 3'd1, 1'b1, 16'h0005, 1'b0);
    cyc(8'h00, 3'd2, 1'b1, 16'h0005, 1'b0);
    repeat (3) cyc(8'h05, 3'd0, 1'b0, 16'h0000, 1'b0);
    chk("t2_k2", {15'b0, irq_out}, 16'h0000);
    cyc(8'h05, 3'd0, 1'b0, 16'h0000, 1'b0);
    chk("t2_k3", {15'b0, irq_out}, 16'h0001);
    chk("t2_id0", {12'b0, irq_id}, 16'h0000);
    cyc(8'h05, 3'd0, 1'b0, 16'h0000, 1'b1);
    rd(3'd3, d);
    chk("t2_svc", d, 16'h8000);
    idle(1);
    rd(3'd0, d);
    chk("t2_pend", d, 16'h0004);
    cyc(8'h05, 3'd4, 1'b1, 16'h0000, 1'b0);
    chk("t2_gap", {15'b0, irq_out}, 16'h0000);
    idle(1);
    chk("t2_req2", {11'b0, irq_out, irq_id}, 16'h0012);
    cyc(8'h05, 3'd0, 1'b0, 16'h0000, 1'b1);
    cyc(8'h05, 3'd4, 1'b1, 16'h0000, 1'b0);
    cyc(8'h00, 3'd0, 1'b0, 16'h0000, 1'b0);
    idle(3);

    // Level source re-requests after EOI, and withdraws when dropped.
    cyc(8'h00, 3'd2, 1'b1, 16'h0000, 1'b0);
    cyc(8'h00, 3'd1, 1'b1, 16'h0008, 1'b0);
    repeat (4) cyc(8'h08, 3'd0, 1'b0, 16'h0000, 1'b0);
    chk("t3_req", {11'b0, irq_out, irq_id}, 16'h0013);
    cyc(8'h08, 3'd0, 1'b0, 16'h0000, 1'b1);
    cyc(8'h08, 3'd4, 1'b1, 16'h0000, 1'b0);
    idle(1);
    chk("t3_rereq", {11'b0, irq_out, irq_id}, 16'h0013);
    repeat (4) cyc(8'h00, 3'd0, 1'b0, 16'h0000, 1'b0);
    chk("t3_drop", {15'b0, irq_out}, 16'h0000);
    rd(3'd3, d);
    chk("t3_stat", d, 16'h0003);

    // Take beats a same-cycle mask-off; without take the request withdraws.
    cyc(8'h00, 3'd2, 1'b1, 16'h0002, 1'b0);
    cyc(8'h00, 3'd1, 1'b1, 16'h0002, 1'b0);
    repeat (4) cyc(8'h02, 3'd0, 1'b0, 16'h0000, 1'b0);
    chk("t4_req", {11'b0, irq_out, irq_id}, 16'h0011);
    cyc(8'h02, 3'd1, 1'b1, 16'h0000, 1'b1);
    rd(3'd3, d);
    chk("t4_svc", d, 16'h8001);
    cyc(8'h02, 3'd4, 1'b1, 16'h0000, 1'b0);
    repeat (3) cyc(8'h00, 3'd0, 1'b0, 16'h0000, 1'b0);
    cyc(8'h00, 3'd1, 1'b1, 16'h0002, 1'b0);
    repeat (4) cyc(8'h02, 3'd0, 1'b0, 16'h0000, 1'b0);
    cyc(8'h02, 3'd1, 1'b1, 16'h0000, 1'b0);
    idle(1);
    chk("t4_idle", {15'b0, irq_out}, 16'h0000);
    rd(3'd0, d);
    chk("t4_pend", d, 16'h0002);
    cyc(8'h00, 3'd0, 1'b1, 16'h00FF, 1'b0);
    idle(3);

    // Edge set wins over same-cycle W1C; SWI raises a request.
    cyc(8'h02, 3'd0, 1'b0, 16'h0000, 1'b0);
    cyc(8'h02, 3'd0, 1'b0, 16'h0000, 1'b0);
    cyc(8'h02, 3'd0, 1'b1, 16'h0002, 1'b0);
    rd(3'd0, d);
    chk("t5_setwin", d, 16'h0002);
    cyc(8'h02, 3'd0, 1'b1, 16'h0002, 1'b0);
    cyc(8'h02, 3'd2, 1'b1, 16'h0012, 1'b0);
    cyc(8'h02, 3'd1, 1'b1, 16'h0010, 1'b0);
    cyc(8'h02, 3'd5, 1'b1, 16'h0010, 1'b0);
    chk("t5_swi1", {15'b0, irq_out}, 16'h0000);
    idle(1);
    chk("t5_swi2", {11'b0, irq_out, irq_id}, 16'h0014);

    // Asynchronous reset in SERVICE takes effect without a clock edge.
    cyc(8'h02, 3'd0, 1'b0, 16'h0000, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_irq", {11'b0, irq_out, irq_id}, 16'h0000);
    reg_sel = 3'd1;
    #1;
    chk("rst_mask", reg_rdata, 16'h0000);
    reg_sel = 3'd3;
    #1;
    chk("rst_stat", reg_rdata, 16'h0000);
    m_reset();
    cur_src = 8'h00;
    irq_src = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_all();

    // Randomized traffic against the model.
    cyc(8'h00, 3'd1, 1'b1, 16'h00FF, 1'b0);
    for (int c = 0; c < 1500; c++) begin
      logic [7:0]  flip;
      logic        we;
      logic [2:0]  sel;
      logic [15:0] wd;
      logic        tk;
      flip = 8'($urandom) & 8'($urandom) & 8'($urandom);
      we   = ($urandom_range(0, 3) == 0);
      sel  = 3'($urandom_range(0, 7));
      wd   = 16'($urandom);
      tk   = ($urandom_range(0, 2) == 0);
      cyc(cur_src ^ flip, sel, we, wd, tk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
